// File: rtl/fmac_pkg.sv
// Shared definitions for the FMAC issue arbiter: rounding-mode encodings,
// IEEE flag bit positions, canonical NaN and the tag carried alongside each op.
package fmac_pkg;

  localparam int unsigned RM_W = 3;

  localparam logic [RM_W-1:0] RM_RNE = 3'b000;
  localparam logic [RM_W-1:0] RM_RTZ = 3'b001;
  localparam logic [RM_W-1:0] RM_RDN = 3'b010;
  localparam logic [RM_W-1:0] RM_RUP = 3'b011;
  localparam logic [RM_W-1:0] RM_RMM = 3'b100;
  localparam logic [RM_W-1:0] RM_DYN = 3'b111;

  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  typedef struct packed {
    logic valid;
    logic id;
    logic illegal;
  } tag_t;

endpackage

// File: rtl/fmac_tag_pipe.sv
// Enable-gated shift register carrying op tags alongside the MAC datapath.
// DEPTH=0 degenerates to a wire.
module fmac_tag_pipe
  import fmac_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic Clk_i,
  input  logic Rst_i,
  input  logic En_i,
  input  tag_t Tag_i,
  output tag_t Tag_o
);

  if (DEPTH == 0) begin : g_wire
    assign Tag_o = Tag_i;
  end else begin : g_regs
    tag_t stages [DEPTH];

    always_ff @(posedge Clk_i) begin
      if (Rst_i) begin
        for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
      end else if (En_i) begin
        stages[0] <= Tag_i;
        for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
      end
    end

    assign Tag_o = stages[DEPTH-1];
  end

endmodule

// File: rtl/fmac_issue_arbiter.sv
// Two-requester round-robin issue arbiter for a shared fixed-latency FP32 MAC.
// Optional sticky-flag accumulation is enabled with `define FMAC_FLAG_ACC_EN.
module fmac_issue_arbiter
  import fmac_pkg::*;
#(
  parameter int                PARM_RM        = 3,
  parameter int                PARM_XLEN      = 32,
  parameter int                PARM_LAT       = 3,
  parameter logic [PARM_RM-1:0] PARM_RM_DYN   = 3'b111,
  parameter logic [PARM_XLEN-1:0] PARM_CANON_NAN = 32'h7FC0_0000
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  input  logic                 Req0_valid_i,
  output logic                 Req0_ready_o,
  input  logic [PARM_XLEN-1:0] Req0_A_i,
  input  logic [PARM_XLEN-1:0] Req0_B_i,
  input  logic [PARM_XLEN-1:0] Req0_C_i,
  input  logic [PARM_RM-1:0]   Req0_rm_i,
  input  logic                 Req1_valid_i,
  output logic                 Req1_ready_o,
  input  logic [PARM_XLEN-1:0] Req1_A_i,
  input  logic [PARM_XLEN-1:0] Req1_B_i,
  input  logic [PARM_XLEN-1:0] Req1_C_i,
  input  logic [PARM_RM-1:0]   Req1_rm_i,
  input  logic [PARM_RM-1:0]   Frm_i,
  output logic                 Mac_en_o,
  output logic                 Mac_valid_o,
  output logic [PARM_XLEN-1:0] Mac_A_o,
  output logic [PARM_XLEN-1:0] Mac_B_o,
  output logic [PARM_XLEN-1:0] Mac_C_o,
  output logic [PARM_RM-1:0]   Mac_rm_o,
  input  logic [PARM_XLEN-1:0] Mac_result_i,
  input  logic [4:0]           Mac_flags_i,
  output logic                 Resp_valid_o,
  input  logic                 Resp_ready_i,
  output logic                 Resp_id_o,
  output logic [PARM_XLEN-1:0] Resp_result_o,
  output logic [4:0]           Resp_flags_o,
  output logic                 Resp_illegal_o,
  output logic [4:0]           Fflags0_o,
  output logic [4:0]           Fflags1_o,
  input  logic [1:0]           Fflags_clr_i
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // Request valid never waits on ready; ready is a combinational function of
  // valid, the round-robin pointer and the response stall. Resp_valid_o is
  // registered and holds its payload until Resp_ready_i is seen.

  logic                 rr_ptr_q;
  logic                 grant0, grant1, any_grant;
  logic [PARM_RM-1:0]   rm_sel, rm_res;
  logic                 rm_illegal;
  tag_t                 issue_tag, tail_tag;

  logic                 resp_valid_q, resp_id_q, resp_illegal_q;
  logic [PARM_XLEN-1:0] resp_result_q;
  logic [4:0]           resp_flags_q;

  // Reset also gates the enable so nothing is granted while the block clears.
  assign Mac_en_o = ~Rst_i & (~resp_valid_q | Resp_ready_i);

  assign grant0    = Mac_en_o & Req0_valid_i & (~Req1_valid_i | ~rr_ptr_q);
  assign grant1    = Mac_en_o & Req1_valid_i & (~Req0_valid_i |  rr_ptr_q);
  assign any_grant = grant0 | grant1;

  assign Req0_ready_o = grant0;
  assign Req1_ready_o = grant1;

  assign rm_sel     = grant1 ? Req1_rm_i : Req0_rm_i;
  assign rm_res     = (rm_sel == PARM_RM_DYN) ? Frm_i : rm_sel;
  assign rm_illegal = rm_res > PARM_RM'(RM_RMM);

  assign Mac_valid_o = any_grant & ~rm_illegal;
  assign Mac_A_o     = Mac_valid_o ? (grant1 ? Req1_A_i : Req0_A_i) : '0;
  assign Mac_B_o     = Mac_valid_o ? (grant1 ? Req1_B_i : Req0_B_i) : '0;
  assign Mac_C_o     = Mac_valid_o ? (grant1 ? Req1_C_i : Req0_C_i) : '0;
  assign Mac_rm_o    = Mac_valid_o ? rm_res : '0;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      rr_ptr_q <= 1'b0;
    end else if (any_grant) begin
      rr_ptr_q <= grant0;
    end
  end

  assign issue_tag = '{valid: any_grant, id: grant1, illegal: any_grant & rm_illegal};

  // The response register is the final stage, so the tag chain is one shorter.
  fmac_tag_pipe #(
    .DEPTH (PARM_LAT - 1)
  ) u_tag_pipe (
    .Clk_i (Clk_i),
    .Rst_i (Rst_i),
    .En_i  (Mac_en_o),
    .Tag_i (issue_tag),
    .Tag_o (tail_tag)
  );

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      resp_valid_q   <= 1'b0;
      resp_id_q      <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_result_q  <= '0;
      resp_flags_q   <= '0;
    end else if (Mac_en_o) begin
      resp_valid_q   <= tail_tag.valid;
      resp_id_q      <= tail_tag.valid & tail_tag.id;
      resp_illegal_q <= tail_tag.valid & tail_tag.illegal;
      if (tail_tag.valid && tail_tag.illegal) begin
        resp_result_q <= PARM_CANON_NAN;
        resp_flags_q  <= '0;
      end else if (tail_tag.valid) begin
        resp_result_q <= Mac_result_i;
        resp_flags_q  <= Mac_flags_i;
      end else begin
        resp_result_q <= '0;
        resp_flags_q  <= '0;
      end
    end
  end

  assign Resp_valid_o   = resp_valid_q;
  assign Resp_id_o      = resp_id_q;
  assign Resp_illegal_o = resp_illegal_q;
  assign Resp_result_o  = resp_result_q;
  assign Resp_flags_o   = resp_flags_q;

`ifdef FMAC_FLAG_ACC_EN
  logic [4:0] fflags0_q, fflags1_q;
  logic       acc;

  assign acc = resp_valid_q & Resp_ready_i & ~resp_illegal_q;

  // A clear on the same cycle as an accumulate wins and drops those flags.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      fflags0_q <= '0;
      fflags1_q <= '0;
    end else begin
      if (Fflags_clr_i[0])            fflags0_q <= '0;
      else if (acc && !resp_id_q)     fflags0_q <= fflags0_q | resp_flags_q;
      if (Fflags_clr_i[1])            fflags1_q <= '0;
      else if (acc && resp_id_q)      fflags1_q <= fflags1_q | resp_flags_q;
    end
  end

  assign Fflags0_o = fflags0_q;
  assign Fflags1_o = fflags1_q;
`else
  logic unused_fflags_clr;
  assign unused_fflags_clr = ^Fflags_clr_i;
  assign Fflags0_o = '0;
  assign Fflags1_o = '0;
`endif

endmodule

// File: doc/fmac_issue_arbiter.md
Name: fmac_issue_arbiter

Overview:
- Shares one fixed-latency FP32 multiply-add pipeline (A + B*C, ending in the rounder stage) between two requesters.
- Round-robin arbitration with valid/ready handshakes.
- Resolves the dynamic rounding mode and carries each request's tag through the pipeline.
- Stalls the whole pipeline on response backpressure; routes results and IEEE flags back in order.

Parameters:
PARM_RM, 3, rounding-mode width
PARM_XLEN, 32, operand/result width
PARM_LAT, 3, MAC pipeline latency in enabled cycles (>=1)
PARM_RM_DYN, 3'b111, rm encoding meaning "use Frm_i"
PARM_CANON_NAN, 32'h7FC0_0000, result returned for illegal rounding mode

Ports:
Clk_i  in  1  clock
Rst_i  in  1  synchronous active-high reset
Req0_valid_i  in  1  requester 0 has an operation
Req0_ready_o  out  1  requester 0 accepted this cycle
Req0_A_i / Req0_B_i / Req0_C_i  in  XLEN each  requester 0 operands
Req0_rm_i  in  RM  requester 0 rounding mode
Req1_*  same set as Req0_* for requester 1
Frm_i  in  RM  dynamic rounding mode (fcsr.frm)
Mac_en_o  out  1  pipeline advance enable, drives every MAC stage register
Mac_valid_o  out  1  issue slot carries a real operation
Mac_A_o / Mac_B_o / Mac_C_o  out  XLEN each  issued operands
Mac_rm_o  out  RM  resolved rounding mode (never 101/110/111)
Mac_result_i  in  XLEN  rounder output, PARM_LAT enabled cycles after issue
Mac_flags_i  in  5  {NV,DZ,OF,UF,NX} from rounder
Resp_valid_o  out  1  response available
Resp_ready_i  in  1  consumer accepts response
Resp_id_o  out  1  requester id of the response
Resp_result_o  out  XLEN  result
Resp_flags_o  out  5  flags for this op
Resp_illegal_o  out  1  op had an illegal rounding mode
Fflags0_o / Fflags1_o  out  5  per-requester sticky flags
Fflags_clr_i  in  2  per-requester sticky clear

Behaviour:
- Reset:
  - all outputs 0; tag pipe empty; round-robin pointer = requester 0.
  - Reset mid-operation discards every in-flight op; no response is produced for it.
- Mac_en_o = ~Resp_valid_o | Resp_ready_i (combinational). When Mac_en_o=0:
  - every ready is 0;
  - the tag pipe and the response register hold their values.
- Arbitration (only while Mac_en_o=1):
  - If exactly one requester is valid, it wins.
  - If both are valid, the pointer's requester wins.
  - After a grant, the pointer moves to the other requester.
  - Winner's ready=1 in the same cycle (ready depends on valid; valid does not depend on ready).
- rm resolution:
  - rm==PARM_RM_DYN: use Frm_i.
  - Resolved value 101, 110 or 111: illegal.
- Issue:
  - Legal op: Mac_valid_o=1 with operands and resolved rm.
  - Illegal op: Mac_valid_o=0 (bubble), but the tag still enters the pipe.
  - No grant: Mac_valid_o=0, empty tag.
  - Throughput: one issue per enabled cycle.
- Tag pipe: PARM_LAT-deep shift register of {valid, id, illegal}, advancing only on Mac_en_o.
- Response register loads on Mac_en_o from the tag pipe tail:
  - Resp_valid_o = tail valid.
  - Legal: Resp_result_o = Mac_result_i, Resp_flags_o = Mac_flags_i.
  - Illegal: result = PARM_CANON_NAN, flags = 0, Resp_illegal_o = 1.
  - Responses leave in issue order.
- Simultaneous response consume and new issue in one cycle is allowed (full throughput under Resp_ready_i=1).

Optional Feature:
- Macro FMAC_FLAG_ACC_EN.
- Defined: Fflags0_o / Fflags1_o OR in Resp_flags_o of legal responses on the accepting handshake (Resp_valid_o & Resp_ready_i), by Resp_id_o.
- Fflags_clr_i[n] clears Fflags n. On the same cycle as a set for n, clear wins and that response's flags are dropped.
- Not defined: both outputs tied 0, Fflags_clr_i ignored.

Decomposition:
- Shared package fmac_pkg: RM encodings (RNE..RMM, DYN), flag bit indices, canonical NaN, tag struct {valid, id, illegal}.
- One natural sub-module, fmac_tag_pipe: parameterised enable-gated shift register.

Test Plan:
1. PARM_LAT=3, Req0 only: A=0x3F800000, B=0x40000000, C=0x40400000, rm=RNE, ready=1.
   -> Mac_valid_o in cycle 0; Resp_valid_o in cycle 3; id=0; result is whatever the model returns (0x40E00000 with a golden MAC).
2. Both requesters valid for 4 cycles -> grants 0,1,0,1; responses return ids 0,1,0,1 in order.
3. Req1 rm=111 with Frm_i=3'b101 -> Mac_valid_o=0 on the issue cycle; 3 cycles later Resp_result_o=0x7FC00000, Resp_illegal_o=1, flags 0.
4. Resp_ready_i=0 while responses are pending -> Mac_en_o=0 and ready=0. The held response is unchanged for 5 cycles; on release no op is lost or duplicated.
5. With FMAC_FLAG_ACC_EN: two Req0 ops returning NX then OF|NX -> Fflags0_o=5'b00101. Clear pulse -> 0. Fflags1_o stays 0.
6. Assert Rst_i with 2 ops in flight -> no responses afterward; the next grant goes to requester 0.
